digit_shift_register: RTL and testbench
=======================================

// Module: digit_shift_register
// PURPOSE
//  Parametrised multi-digit register: successor to the single 4-bit data register.
//  Holds DIGITS digits of WIDTH bits each, packed on q.
//  Supports hold, keypad-style shift-in, single-digit write, parallel load and backspace.
//  Tracks an entered-digit count with full/empty flags.
//  Sits between keypad/input decode and the multi-digit display driver.
// PARAMETERS
//  WIDTH    4  bits per digit (>=4 when DECIMAL=1)
//  DIGITS   4  number of digits (>=2); digit 0 = least significant = q[WIDTH-1:0]
//  DECIMAL  1  1: reject digit values >9 on shift-in/write; 0: accept any value
//  AW       2  wr_addr width, >= $clog2(DIGITS); CW = $clog2(DIGITS+1) derived locally
// PORTS
//  clk             in   1             rising-edge clock
//  reset           in   1             asynchronous, active-low reset
//  clear           in   1             sync clear of all digits and count
//  del             in   1             backspace strobe
//  mode            in   2             00 hold, 01 shift-in, 10 write digit, 11 parallel load
//  data            in   WIDTH         digit for shift-in / write
//  wr_addr         in   AW            digit index for mode 10
//  load_bus        in   WIDTH*DIGITS  image for mode 11
//  q               out  WIDTH*DIGITS  registered digit contents
//  count           out  CW            entered digits, 0..DIGITS
//  full            out  1             count==DIGITS
//  empty           out  1             count==0
//  shift_out       out  WIDTH         digit pushed out of top on overflow
//  shift_out_valid out  1             1-cycle pulse with shift_out
//  err             out  1             1-cycle pulse: rejected data or bad address
// BEHAVIOUR
//  Reset (reset=0, asynchronous): q=0, count=0, shift_out=0, shift_out_valid=0, err=0.
//  All other updates occur on the rising clk edge; outputs are registered, 1-cycle latency.
//  Priority per cycle: clear > del > mode. Lower-priority requests in the same cycle are dropped.
//  clear: q=0, count=0.
//  del: digit i <= digit i+1 for i<DIGITS-1; top digit <= 0; count <= max(count-1,0).
//  del when empty: shifts q anyway; count stays 0; no err.
//  mode 00: all state holds.
//  mode 01 shift-in: digit0 <= data; digit i <= digit i-1; count <= min(count+1,DIGITS).
//    When full before the shift: shift_out <= old top digit, shift_out_valid=1.
//  mode 10 write: digit[wr_addr] <= data; count unchanged.
//    wr_addr >= DIGITS: no state change, err=1.
//  mode 11 load: q <= load_bus; count <= DIGITS. No DECIMAL check on this path.
//  DECIMAL=1 and data>9 in modes 01/10: no state change, err=1.
//  full and empty are combinational decodes of the count register.
//  shift_out_valid and err are high for exactly one cycle after the triggering edge.
//  shift_out holds its last value between pulses.
//  Reset asserted mid-operation overrides everything immediately; the first edge after release acts normally.
// TESTING  (WIDTH=4, DIGITS=4, DECIMAL=1)
//  1. reset=0 then release, mode=00 x3 -> q=16'h0000, count=0, empty=1, err=0.
//  2. shift-in 1,2,3,4 -> q=16'h1234, count=4, full=1;
//     shift-in 5 -> q=16'h2345, shift_out=1, shift_out_valid=1 for 1 cycle.
//  3. From q=16'h1234, count=4: del -> q=16'h0123, count=3;
//     del x4 -> q=0, count=0, no err.
//  4. From q=16'h1234: write data=9 @ addr 2 -> q=16'h1934;
//     data=4'hA @ addr 0 -> q unchanged, err pulse;
//     shift-in 4'hC -> rejected, err pulse.
//  5. load 16'hABCD -> q=16'hABCD, count=4;
//     same cycle clear=1 with mode=01 -> q=0, count=0.
//     clear+del together -> clear wins.
//  6. Mid-sequence (q=16'h0012): pulse reset low between edges -> q=0 at once, no clk needed;
//     release, then shift-in 7 -> q=16'h0007, count=1.

Source files
------------

// File: rtl/digit_shift_register.sv
// digit_shift_register: multi-digit register with keypad shift-in, digit write, parallel load, backspace
// Tracks how many digits have been entered and flags overflow and rejected input.
module digit_shift_register #(
  parameter int WIDTH   = 4,
  parameter int DIGITS  = 4,
  parameter int DECIMAL = 1,
  parameter int AW      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      del,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          data,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH*DIGITS-1:0]   load_bus,
  output logic [WIDTH*DIGITS-1:0]   q,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic [WIDTH-1:0]          shift_out,
  output logic                      shift_out_valid,
  output logic                      err
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int N  = WIDTH*DIGITS;
  localparam logic [WIDTH-1:0] MAX_DEC = WIDTH'(9);
  logic [N-1:0]       q_q, q_d, wr_img;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   so_q, so_d;
  logic               sov_q, sov_d, err_q, err_d;
  logic               bad_data, bad_addr;
  assign full  = count_q == CW'(DIGITS);
  assign empty = count_q == '0;
  assign bad_data = (DECIMAL != 0) && (data > MAX_DEC);
  assign bad_addr = 32'(wr_addr) >= DIGITS;
  always_comb begin
    wr_img = q_q;
    for (int i = 0; i < DIGITS; i++)
      if (32'(wr_addr) == i) wr_img[i*WIDTH +: WIDTH] = data;
  end
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    so_d    = so_q;
    sov_d   = 1'b0;
    err_d   = 1'b0;
    if (clear) begin
      q_d     = '0;
      count_d = '0;
    end else if (del) begin
      q_d     = {{WIDTH{1'b0}}, q_q[N-1:WIDTH]};
      count_d = empty ? '0 : count_q - CW'(1);
    end else if (mode == 2'b01) begin
      err_d = bad_data;
      if (!bad_data) begin
        q_d     = {q_q[N-WIDTH-1:0], data};
        count_d = full ? count_q : count_q + CW'(1);
        so_d    = full ? q_q[N-1 -: WIDTH] : so_q;
        sov_d   = full;
      end
    end else if (mode == 2'b10) begin
      err_d = bad_data || bad_addr;
      q_d   = err_d ? q_q : wr_img;
    end else if (mode == 2'b11) begin
      q_d     = load_bus;
      count_d = CW'(DIGITS);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= '0;
      count_q <= '0;
      so_q    <= '0;
      sov_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      so_q    <= so_d;
      sov_q   <= sov_d;
      err_q   <= err_d;
    end
  end
  assign q               = q_q;
  assign count           = count_q;
  assign shift_out       = so_q;
  assign shift_out_valid = sov_q;
  assign err             = err_q;
endmodule

// File: tb/tb_digit_shift_register.sv
// tb_digit_shift_register: directed and random checks against a digit-array reference model
module tb_digit_shift_register;
  logic        clk = 0, reset = 0, clear = 0, del = 0;
  logic [1:0]  mode = 0;
  logic [3:0]  data = 0, shift_out;
  logic [1:0]  wr_addr = 0;
  logic [15:0] load_bus = 0, q;
  logic [2:0]  count;
  logic        full, empty, shift_out_valid, err;
  int n_checks = 0, n_fail = 0;
  int dig[4];
  int cnt = 0, e_so = 0, e_sov = 0, e_err = 0;
  digit_shift_register #(.WIDTH(4), .DIGITS(4), .DECIMAL(1), .AW(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .del(del), .mode(mode), .data(data),
    .wr_addr(wr_addr), .load_bus(load_bus), .q(q), .count(count), .full(full),
    .empty(empty), .shift_out(shift_out), .shift_out_valid(shift_out_valid), .err(err));
  always #5 clk = ~clk;
  function automatic logic [15:0] mq();
    logic [15:0] r = 0;
    for (int i = 0; i < 4; i++) r = r + 16'(dig[i] * (1 << (4 * i)));
    return r;
  endfunction
  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) dig[i] = 0;
    cnt = 0; e_so = 0; e_sov = 0; e_err = 0;
  endtask
  task automatic step(input logic c, input logic d, input logic [1:0] m, input logic [3:0] dt,
                      input logic [1:0] a, input logic [15:0] lb);
    @(negedge clk);
    clear = c; del = d; mode = m; data = dt; wr_addr = a; load_bus = lb;
    @(posedge clk);
    e_sov = 0; e_err = 0;
    if (c) begin
      mdl_reset_digits();
    end else if (d) begin
      for (int i = 0; i < 3; i++) dig[i] = dig[i+1];
      dig[3] = 0;
      cnt = cnt > 0 ? cnt - 1 : 0;
    end else if (m == 1) begin
      if (dt > 9) e_err = 1;
      else begin
        if (cnt == 4) begin e_so = dig[3]; e_sov = 1; end
        for (int i = 3; i > 0; i--) dig[i] = dig[i-1];
        dig[0] = dt;
        cnt = cnt < 4 ? cnt + 1 : 4;
      end
    end else if (m == 2) begin
      if (dt > 9 || a >= 4) e_err = 1;
      else dig[a] = dt;
    end else if (m == 3) begin
      for (int i = 0; i < 4; i++) dig[i] = (lb >> (4 * i)) & 15;
      cnt = 4;
    end
    #1;
  endtask
  task automatic mdl_reset_digits();
    for (int i = 0; i < 4; i++) dig[i] = 0;
    cnt = 0;
  endtask
  task automatic hold(); step(0, 0, 2'b00, 0, 0, 0); endtask
  task automatic shin(input logic [3:0] v); step(0, 0, 2'b01, v, 0, 0); endtask
  task automatic test_reset();
    reset = 0; #1;
    n_checks++; if (q !== 16'h0 || count !== 0 || err !== 0 || shift_out_valid !== 0) begin
      n_fail++; $display("FAIL reset_async q=%h count=%0d err=%b sov=%b, want 0", q, count, err, shift_out_valid); end
    @(negedge clk); reset = 1; mdl_reset();
    repeat (3) hold();
    n_checks++; if (q !== 16'h0 || count !== 0 || empty !== 1 || full !== 0 || err !== 0) begin
      n_fail++; $display("FAIL reset_hold q=%h count=%0d empty=%b err=%b, want 0000/0/1/0", q, count, empty, err); end
  endtask
  task automatic test_shift();
    for (int i = 1; i <= 4; i++) shin(4'(i));
    n_checks++; if (q !== 16'h1234 || count !== 3'(cnt) || full !== 1 || shift_out_valid !== 0) begin
      n_fail++; $display("FAIL shift_fill q=%h count=%0d full=%b sov=%b, want 1234/4/1/0", q, count, full, shift_out_valid); end
    shin(5);
    n_checks++; if (q !== 16'h2345 || shift_out !== 4'd1 || shift_out_valid !== 1 || q !== mq()) begin
      n_fail++; $display("FAIL shift_overflow q=%h so=%h sov=%b, want 2345/1/1", q, shift_out, shift_out_valid); end
    hold();
    n_checks++; if (shift_out_valid !== 0 || shift_out !== 4'd1 || count !== 3'd4) begin
      n_fail++; $display("FAIL shift_pulse sov=%b so=%h count=%0d, want 0/1/4", shift_out_valid, shift_out, count); end
  endtask
  task automatic test_del();
    step(0, 0, 2'b11, 0, 0, 16'h1234);
    step(0, 1, 2'b00, 0, 0, 0);
    n_checks++; if (q !== 16'h0123 || count !== 3'd3) begin
      n_fail++; $display("FAIL del_one q=%h count=%0d, want 0123/3", q, count); end
    repeat (4) begin
      step(0, 1, 2'b00, 0, 0, 0);
      n_checks++; if (err !== 0 || q !== mq() || count !== 3'(cnt)) begin
        n_fail++; $display("FAIL del_run q=%h count=%0d err=%b, want %h/%0d/0", q, count, err, mq(), cnt); end
    end
    n_checks++; if (q !== 16'h0 || count !== 0 || empty !== 1) begin
      n_fail++; $display("FAIL del_empty q=%h count=%0d empty=%b, want 0/0/1", q, count, empty); end
  endtask
  task automatic test_write();
    step(0, 0, 2'b11, 0, 0, 16'h1234);
    step(0, 0, 2'b10, 9, 2, 0);
    n_checks++; if (q !== 16'h1934 || count !== 3'd4 || err !== 0) begin
      n_fail++; $display("FAIL write_ok q=%h count=%0d err=%b, want 1934/4/0", q, count, err); end
    step(0, 0, 2'b10, 4'hA, 0, 0);
    n_checks++; if (q !== 16'h1934 || err !== 1) begin
      n_fail++; $display("FAIL write_reject q=%h err=%b, want 1934/1", q, err); end
    hold();
    n_checks++; if (err !== 0) begin
      n_fail++; $display("FAIL err_pulse err=%b, want 0", err); end
    shin(4'hC);
    n_checks++; if (q !== 16'h1934 || err !== 1 || count !== 3'd4 || shift_out_valid !== 0) begin
      n_fail++; $display("FAIL shift_reject q=%h err=%b count=%0d, want 1934/1/4", q, err, count); end
  endtask
  task automatic test_load_clear();
    step(0, 0, 2'b11, 0, 0, 16'hABCD);
    n_checks++; if (q !== 16'hABCD || count !== 3'd4 || full !== 1) begin
      n_fail++; $display("FAIL load q=%h count=%0d, want ABCD/4", q, count); end
    step(1, 0, 2'b01, 3, 0, 0);
    n_checks++; if (q !== 16'h0 || count !== 0 || empty !== 1) begin
      n_fail++; $display("FAIL clear_vs_shift q=%h count=%0d, want 0/0", q, count); end
    step(0, 0, 2'b11, 0, 0, 16'h5678);
    step(1, 1, 2'b00, 0, 0, 0);
    n_checks++; if (q !== 16'h0 || count !== 0) begin
      n_fail++; $display("FAIL clear_vs_del q=%h count=%0d, want 0/0", q, count); end
    shin(3);
    step(0, 1, 2'b01, 8, 0, 0);
    n_checks++; if (q !== 16'h0 || count !== 0 || err !== 0) begin
      n_fail++; $display("FAIL del_vs_shift q=%h count=%0d, want 0/0", q, count); end
  endtask
  task automatic test_async_reset();
    shin(1); shin(2);
    n_checks++; if (q !== 16'h0012 || count !== 3'd2) begin
      n_fail++; $display("FAIL pre_reset q=%h count=%0d, want 0012/2", q, count); end
    #1 reset = 0; #1;
    n_checks++; if (q !== 16'h0 || count !== 0) begin
      n_fail++; $display("FAIL async_reset q=%h count=%0d, want 0/0", q, count); end
    #1 reset = 1; mdl_reset();
    shin(7);
    n_checks++; if (q !== 16'h0007 || count !== 3'd1) begin
      n_fail++; $display("FAIL post_reset q=%h count=%0d, want 0007/1", q, count); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 16'($urandom));
      n_checks++;
      if ({q, count, full, empty, shift_out, shift_out_valid, err} !==
          {mq(), 3'(cnt), cnt == 4, cnt == 0, 4'(e_so), e_sov != 0, e_err != 0}) begin
        n_fail++;
        $display("FAIL random[%0d] q=%h cnt=%0d so=%h sov=%b err=%b, want %h/%0d/%h/%0d/%0d",
                 n, q, count, shift_out, shift_out_valid, err, mq(), cnt, e_so, e_sov, e_err);
      end
    end
  endtask
  initial begin
    mdl_reset();
    test_reset();
    test_shift();
    test_del();
    test_write();
    test_load_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
